pc_fetch_unit: RTL and testbench

- Program-counter and instruction-fetch stage of the RISC-V core.
- Sits directly upstream of decode/execute, including the branch unit. Owns the architectural PC and fetches the instruction word at that PC from instruction memory over a req/ack handshake.
- Presents iaddr/idata to execute, then waits for execute to return the next PC; for branches this is the branch unit's iaddr_val.
- Counts retired instructions and flags fetch timeouts.

---
 rtl/pc_fetch_unit_if.sv | 38 +++
 rtl/pc_fetch_unit.sv | 112 +++++++++++
 tb/tb_pc_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// ---------------------------------------------------------------
// pc_fetch_unit_if : instruction-memory and execute-side signals
// of the fetch stage. Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        npc_valid;
  logic [31:0] npc;
  logic        stall;
  logic        fetch_fault;
  logic [31:0] instret;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, iaddr, idata,
    input  npc_valid, npc, stall,
    output fetch_fault, instret
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, iaddr, idata,
    output npc_valid, npc, stall,
    input  fetch_fault, instret
  );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------
// pc_fetch_unit : architectural PC, instruction fetch and retire count.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned next PC halts with a fault.
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  pc_fetch_unit_if.master   bus
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] iaddr_q, iaddr_nxt;
  logic [31:0] idata_q, idata_nxt;
  logic [31:0] instret_cnt, instret_nxt;
  logic [15:0] wait_cnt, wait_nxt;
  logic        fault_q, fault_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_VECTOR;
      iaddr_q     <= 32'h0000_0000;
      idata_q     <= NOP_INSTR;
      instret_cnt <= 32'h0000_0000;
      wait_cnt    <= 16'h0000;
      fault_q     <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      iaddr_q     <= iaddr_nxt;
      idata_q     <= idata_nxt;
      instret_cnt <= instret_nxt;
      wait_cnt    <= wait_nxt;
      fault_q     <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    iaddr_nxt   = iaddr_q;
    idata_nxt   = idata_q;
    instret_nxt = instret_cnt;
    wait_nxt    = wait_cnt;
    fault_nxt   = fault_q;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (bus.imem_ack) begin
          idata_nxt = bus.imem_rdata;
          iaddr_nxt = pc;
          wait_nxt  = 16'h0000;
          state_nxt = EXEC;
        end else if (wait_cnt == WAIT_LAST) begin
          fault_nxt = 1'b1;
          state_nxt = HALT;
        end else begin
          wait_nxt = wait_cnt + 16'h0001;
        end
      end
      EXEC: begin
        if (bus.npc_valid && !bus.stall) begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (bus.npc[1:0] != 2'b00) begin
            fault_nxt = 1'b1;
            state_nxt = HALT;
          end else begin
            pc_nxt      = bus.npc;
            instret_nxt = instret_cnt + 32'h0000_0001;
            state_nxt   = FETCH;
          end
`else
          pc_nxt      = bus.npc & ~32'h0000_0003;
          instret_nxt = instret_cnt + 32'h0000_0001;
          state_nxt   = FETCH;
`endif
        end
      end
      HALT:    fault_nxt = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.imem_req    = (state == FETCH);
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = (state == EXEC);
  assign bus.iaddr       = iaddr_q;
  assign bus.idata       = idata_q;
  assign bus.fetch_fault = fault_q;
  assign bus.instret     = instret_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------
// tb_pc_fetch_unit : randomized bench for pc_fetch_unit against a
// transaction-level PC / retire-count model. Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_pc_fetch_unit;

  localparam logic [31:0] RV      = 32'h0000_0000;
  localparam int          TIMEOUT = 4;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_instret;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_VECTOR(RV), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Waits for a request, then answers after the given number of idle cycles.
  task automatic do_fetch(input logic [31:0] word, input int waits, output bit ok,
                          output logic [31:0] addr_seen);
    ok = 1'b0;
    addr_seen = 32'hx;
    for (int i = 0; i < 8; i++) begin
      if (bus.imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) return;
    addr_seen = bus.imem_addr;
    for (int i = 0; i < waits; i++) begin
      bus.npc_valid = 1'($urandom);
      bus.npc       = $urandom;
      bus.stall     = 1'($urandom);
      @(negedge clk);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    bus.npc_valid  = 1'b0;
    bus.stall      = 1'b0;
  endtask

  task automatic do_accept(input logic [31:0] n, input int stalls);
    bus.npc_valid = 1'b1;
    bus.npc       = n;
    bus.stall     = 1'b1;
    for (int i = 0; i < stalls; i++) begin
      bus.imem_ack = 1'($urandom);
      @(negedge clk);
    end
    bus.stall    = 1'b0;
    bus.imem_ack = 1'($urandom);
    @(negedge clk);
    bus.npc_valid = 1'b0;
    bus.imem_ack  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
    bus.npc_valid = 1'b0; bus.npc = 32'h0; bus.stall = 1'b0;
    repeat (2) @(negedge clk);
    exp_pc = RV;
    exp_instret = 32'h0;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== RV) begin errors++; $display("FAIL reset_addr: got %h want %h", bus.imem_addr, RV); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
    checks++; if (bus.iaddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr: got %h want 0", bus.iaddr); end
    checks++; if (bus.idata !== NOP) begin errors++; $display("FAIL reset_idata: got %h want %h", bus.idata, NOP); end
    checks++; if (bus.fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", bus.fetch_fault); end
    checks++; if (bus.instret !== 32'h0) begin errors++; $display("FAIL reset_instret: got %h want 0", bus.instret); end
  endtask

  task automatic test_first_fetch();
    bit ok;
    logic [31:0] a;
    rst_n = 1'b1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", bus.imem_req); end
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== RV) begin errors++; $display("FAIL first_addr: got %h want %h", bus.imem_addr, RV); end
    do_fetch(32'h0000_0063, 1, ok, a);
    checks++; if (!ok) begin errors++; $display("FAIL first_fetch_timeout: got no request want request"); end
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", bus.instr_valid); end
    checks++; if (bus.iaddr !== RV) begin errors++; $display("FAIL first_iaddr: got %h want %h", bus.iaddr, RV); end
    checks++; if (bus.idata !== 32'h0000_0063) begin errors++; $display("FAIL first_idata: got %h want 00000063", bus.idata); end
  endtask

  task automatic test_branch();
    bit ok;
    logic [31:0] a;
    logic [31:0] w;
    do_accept(32'h0000_0100, 0);
    exp_pc = 32'h0000_0100; exp_instret++;
    w = $urandom;
    do_fetch(w, 0, ok, a);
    checks++; if (bus.iaddr !== 32'h0000_0100 || !ok) begin errors++; $display("FAIL br_iaddr: got %h want 00000100", bus.iaddr); end
    checks++; if (bus.idata !== w) begin errors++; $display("FAIL br_idata: got %h want %h", bus.idata, w); end
    do_accept(32'h0000_00F8, 0);
    exp_pc = 32'h0000_00F8; exp_instret++;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_00F8) begin errors++;
      $display("FAIL br_target: got req=%b addr=%h want req=1 addr=000000f8", bus.imem_req, bus.imem_addr); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL br_valid: got %b want 0", bus.instr_valid); end
    checks++; if (bus.instret !== exp_instret) begin errors++; $display("FAIL br_instret: got %h want %h", bus.instret, exp_instret); end
    do_fetch($urandom, 0, ok, a);
  endtask

  task automatic test_stall();
    logic [31:0] n;
    n = 32'h0000_4000;
    bus.npc_valid = 1'b1; bus.npc = n; bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0 || bus.iaddr !== exp_pc) begin errors++;
        $display("FAIL stall_hold%0d: got valid=%b req=%b iaddr=%h want 1 0 %h", i, bus.instr_valid, bus.imem_req, bus.iaddr, exp_pc); end
      checks++; if (bus.imem_addr !== exp_pc || bus.instret !== exp_instret) begin errors++;
        $display("FAIL stall_pc%0d: got pc=%h instret=%h want %h %h", i, bus.imem_addr, bus.instret, exp_pc, exp_instret); end
    end
    bus.stall = 1'b0;
    @(negedge clk);
    bus.npc_valid = 1'b0;
    exp_pc = n; exp_instret++;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== n) begin errors++;
      $display("FAIL stall_accept: got req=%b addr=%h want 1 %h", bus.imem_req, bus.imem_addr, n); end
  endtask

  task automatic test_misalign();
    bit ok;
    logic [31:0] a;
    do_fetch($urandom, 0, ok, a);
    do_accept(32'h0000_0102, 0);
`ifdef FETCH_ALIGN_CHECK_EN
    checks++; if (bus.fetch_fault !== 1'b1 || bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin errors++;
      $display("FAIL misalign_fault: got fault=%b valid=%b req=%b want 1 0 0", bus.fetch_fault, bus.instr_valid, bus.imem_req); end
    checks++; if (bus.instret !== exp_instret) begin errors++; $display("FAIL misalign_instret: got %h want %h", bus.instret, exp_instret); end
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    exp_pc = RV; exp_instret = 32'h0;
`else
    exp_pc = 32'h0000_0100; exp_instret++;
    checks++; if (bus.imem_addr !== 32'h0000_0100 || bus.fetch_fault !== 1'b0) begin errors++;
      $display("FAIL misalign_clear: got addr=%h fault=%b want 00000100 0", bus.imem_addr, bus.fetch_fault); end
    checks++; if (bus.instret !== exp_instret) begin errors++; $display("FAIL misalign_instret: got %h want %h", bus.instret, exp_instret); end
`endif
    do_fetch($urandom, 0, ok, a);
    checks++; if (!ok || bus.iaddr !== exp_pc) begin errors++; $display("FAIL misalign_refetch: got %h want %h", bus.iaddr, exp_pc); end
  endtask

  task automatic test_instret_wrap();
    force dut.instret_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.instret_cnt;
    exp_instret = 32'hFFFF_FFFF;
    do_accept(32'h0000_0200, 1);
    exp_pc = 32'h0000_0200; exp_instret++;
    checks++; if (bus.instret !== 32'h0) begin errors++; $display("FAIL instret_wrap: got %h want 00000000", bus.instret); end
  endtask

  task automatic test_random();
    bit ok;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] n;
    for (int it = 0; it < 40; it++) begin
      w = $urandom;
      do_fetch(w, $urandom_range(0, TIMEOUT - 1), ok, a);
      checks++; if (!ok || a !== exp_pc) begin errors++; $display("FAIL rnd_addr%0d: got %h want %h", it, a, exp_pc); end
      checks++; if (bus.instr_valid !== 1'b1 || bus.iaddr !== exp_pc || bus.idata !== w) begin errors++;
        $display("FAIL rnd_present%0d: got v=%b iaddr=%h idata=%h want 1 %h %h", it, bus.instr_valid, bus.iaddr, bus.idata, exp_pc, w); end
      n = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
      n[1:0] = 2'b00;
`endif
      do_accept(n, $urandom_range(0, 2));
      exp_pc = {n[31:2], 2'b00};
      exp_instret++;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc || bus.instret !== exp_instret) begin errors++;
        $display("FAIL rnd_accept%0d: got req=%b addr=%h instret=%h want 1 %h %h", it, bus.imem_req, bus.imem_addr, bus.instret, exp_pc, exp_instret); end
    end
  endtask

  task automatic test_reset_mid_fetch();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL midrst_pre: got req=%b want 1", bus.imem_req); end
    rst_n = 1'b0;
    @(negedge clk);
    exp_pc = RV; exp_instret = 32'h0;
    checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== RV) begin errors++;
      $display("FAIL midrst_req: got req=%b addr=%h want 0 %h", bus.imem_req, bus.imem_addr, RV); end
    checks++; if (bus.instret !== 32'h0 || bus.iaddr !== 32'h0 || bus.idata !== NOP || bus.instr_valid !== 1'b0) begin errors++;
      $display("FAIL midrst_state: got instret=%h iaddr=%h idata=%h valid=%b", bus.instret, bus.iaddr, bus.idata, bus.instr_valid); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    rst_n = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1) begin errors++;
      $display("FAIL late_ack: got valid=%b req=%b want 0 1", bus.instr_valid, bus.imem_req); end
  endtask

  task automatic test_timeout();
    for (int i = 1; i < TIMEOUT; i++) begin
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b1 || bus.fetch_fault !== 1'b0) begin errors++;
        $display("FAIL to_wait%0d: got req=%b fault=%b want 1 0", i, bus.imem_req, bus.fetch_fault); end
    end
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0 || bus.fetch_fault !== 1'b1 || bus.instr_valid !== 1'b0) begin errors++;
      $display("FAIL to_fault: got req=%b fault=%b valid=%b want 0 1 0", bus.imem_req, bus.fetch_fault, bus.instr_valid); end
    bus.imem_ack = 1'b1; bus.npc_valid = 1'b1; bus.npc = 32'h0000_0040; bus.stall = 1'b0;
    repeat (3) @(negedge clk);
    bus.imem_ack = 1'b0; bus.npc_valid = 1'b0;
    checks++; if (bus.fetch_fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instret !== exp_instret) begin errors++;
      $display("FAIL halt_sticky: got fault=%b req=%b valid=%b instret=%h", bus.fetch_fault, bus.imem_req, bus.instr_valid, bus.instret); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.fetch_fault !== 1'b0 || bus.imem_req !== 1'b0 || bus.imem_addr !== RV) begin errors++;
      $display("FAIL halt_reset: got fault=%b req=%b addr=%h want 0 0 %h", bus.fetch_fault, bus.imem_req, bus.imem_addr, RV); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL halt_restart: got req=%b want 1", bus.imem_req); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_first_fetch();
    test_branch();
    test_stall();
    test_misalign();
    test_instret_wrap();
    test_random();
    test_reset_mid_fetch();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
